maze_link_rx: RTL and testbench
===============================

# maze_link_rx

Parametrised receiver for the Arduino-to-FPGA maze link. It samples the asynchronous beat bus (data, strobe, cell address) in the CLOCK_25 domain and reassembles multi-beat cell words. It emits single-cycle write pulses into the VGA cell RAM and tracks the sync, done and error state of the link. It sits between the GPIO_1 link pins and the VGA RAM write port. It replaces the strobe-clocked capture logic in the top level with a fully synchronous, resynchronising, error-checked block.

## Interface
- DATA_W, 3: bits carried per beat
- BEATS, 3: beats per cell word; the word is DATA_W*BEATS bits wide
- ADDR_W, 5: cell address width
- SYNC_ADDR, 2**ADDR_W-1: address value that marks a resync beat
- DONE_ADDR, 2**ADDR_W-2: address value that marks a done beat
- TIMEOUT, 4096: idle CLOCK_25 cycles allowed mid-word before the partial word is aborted
- CLOCK_25  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- link_data  in  DATA_W  asynchronous beat payload
- link_strobe  in  1  asynchronous beat strobe; each rising edge is one beat
- link_addr  in  ADDR_W  asynchronous cell address
- wr_en  out  1  one-cycle write pulse to the VGA RAM
- wr_addr  out  ADDR_W  cell address; valid while wr_en is high
- wr_data  out  DATA_W*BEATS  assembled word; valid while wr_en is high
- done  out  1  maze-complete flag, driven to the renderer and the DDS
- in_word  out  1  high while a partial word is held
- err_count  out  8  saturating count of aborted words
- cell_count  out  ADDR_W+1  saturating count of words written since the last sync beat

## Operation
- All three link inputs pass through two synchronising flops (stages s1, s2).
- A beat event is s2 strobe high while the third strobe flop is low.
- Payload and address are taken from the s2 stage in the cycle the beat event occurs.
- Beat counter beat_cnt runs 0..BEATS-1. `in_word` = (beat_cnt != 0).
- On a beat event, the address selects the action:
  - SYNC_ADDR: beat_cnt <= 0; partial word dropped with no error; cell_count <= 0; done holds.
  - DONE_ADDR: done <= 1; beat_cnt <= 0; a partial word counts as an error.
  - Any other address when beat_cnt == 0: payload goes into slice 0 (bits DATA_W-1:0); word_addr <= addr; beat_cnt <= 1; done <= 0.
  - Any other address when beat_cnt == k>0 and addr == word_addr: payload goes into slice k (LSB-first).
    - If k == BEATS-1: wr_en <= 1 next cycle with the full word; beat_cnt <= 0; cell_count++.
    - Otherwise beat_cnt <= k+1.
  - Any other address when beat_cnt > 0 and addr != word_addr: partial word discarded; err_count++; this beat restarts the word as slice 0 with the new address.
- Timeout: the idle counter clears on every beat event and counts only while in_word.
  - On reaching TIMEOUT-1: beat_cnt <= 0 and err_count++.
  - If the timeout and a beat event fall in the same cycle, the beat wins and no error is counted.
- With BEATS == 1, every ordinary beat produces a write.
- err_count and cell_count saturate and never wrap.

## Timing
- Reset values: wr_en 0, wr_addr 0, wr_data 0, done 0, in_word 0, err_count 0, cell_count 0. All synchroniser flops and the idle counter also clear to 0.
- Strobe latency: let the rising strobe first be sampled at CLOCK_25 edge E0. The beat event is evaluated at edge E2. For a final beat, wr_en is high for exactly the cycle after E2.
- Input stability: link_data and link_addr must be stable from 2 cycles before to 2 cycles after the strobe rise.
- Strobe width: high ≥3 cycles and low ≥3 cycles. Shorter pulses may be missed; this is not flagged.
- wr_addr and wr_data are registered together with wr_en and hold their values until the next write.
- done, in_word and the counters update on the edge that processes the beat.
- A reset asserted mid-word discards the partial word with no error counted. The first beat after reset is treated as slice 0.

## Structure
- Package maze_link_pkg holds:
  - default DATA_W, BEATS and ADDR_W
  - the SYNC/DONE address helper constants
  - cell word field positions: state [8:6], walls N/E/S/W [5:2], treasure [1:0]
  - state encodings: 0 unvisited, 1 visited, 2 unreachable, 3–6 robot heading
- Sub-module link_sync holds the parametrised-width two-flop synchroniser plus the strobe edge detector. It is instantiated once.
- Beat assembly, the idle timer and the counters live in maze_link_rx.

## Test plan
- Reset, then beats (addr 7, data 5,2,6) → one wr_en pulse with wr_addr 7 and wr_data 9'b110_010_101; cell_count 1; err_count 0.
- Beats addr 4 data 1, then addr 9 data 3,0,2 → err_count 1; write to addr 9 with data 9'b010_000_011.
- One beat addr 3, then 4096 idle cycles → in_word drops at the timeout cycle; err_count 1; no write. A following 3-beat word writes normally.
- Beat at addr 30 → done 1. Then addr 31 → done stays 1 and cell_count 0. Then a data beat → done 0.
- Two beats then reset high for 1 cycle, then a 3-beat word at addr 2 → a single write to addr 2 and err_count 0. Repeat with strobe pulses only 2 cycles wide and check that nothing is required (no assertion on dropped beats); with 3-cycle pulses no beat is lost.

Source files
------------

// File: rtl/maze_link_pkg.sv
// ---------------------------------------------------------------------------
// maze_link_pkg
// Shared definitions for the Arduino-to-FPGA maze link receiver.
//   - default beat width, beats per word and cell address width
//   - helpers that derive the reserved SYNC / DONE cell addresses
//   - bit positions of the fields inside an assembled 9-bit cell word
//   - encoding of the cell state field
// ---------------------------------------------------------------------------
package maze_link_pkg;

    localparam int DEF_DATA_W = 3;
    localparam int DEF_BEATS  = 3;
    localparam int DEF_ADDR_W = 5;

    // The two highest cell addresses are reserved for link control beats.
    function automatic int sync_addr_of(input int aw);
        return (1 << aw) - 1;
    endfunction

    function automatic int done_addr_of(input int aw);
        return (1 << aw) - 2;
    endfunction

    // Cell word layout (word is assembled LSB-first, beat 0 lands in [2:0]).
    localparam int CELL_STATE_HI = 8;
    localparam int CELL_STATE_LO = 6;
    localparam int CELL_WALL_N   = 5;
    localparam int CELL_WALL_E   = 4;
    localparam int CELL_WALL_S   = 3;
    localparam int CELL_WALL_W   = 2;
    localparam int CELL_TREAS_HI = 1;
    localparam int CELL_TREAS_LO = 0;

    typedef enum logic [2:0] {
        CELL_UNVISITED   = 3'd0,
        CELL_VISITED     = 3'd1,
        CELL_UNREACHABLE = 3'd2,
        CELL_ROBOT_N     = 3'd3,
        CELL_ROBOT_E     = 3'd4,
        CELL_ROBOT_S     = 3'd5,
        CELL_ROBOT_W     = 3'd6
    } cell_state_e;

    typedef struct packed {
        cell_state_e state;
        logic        wall_n;
        logic        wall_e;
        logic        wall_s;
        logic        wall_w;
        logic [1:0]  treasure;
    } cell_word_t;

endpackage

// File: rtl/maze_link_rx_if.sv
// ---------------------------------------------------------------------------
// maze_link_if
// Bundles the asynchronous link pins (link_data / link_strobe / link_addr)
// with the VGA RAM write port and the link status outputs.
//   master : drives the link pins, observes the write port and status
//   slave  : the receiver; samples the link pins, drives write port/status
// ---------------------------------------------------------------------------
interface maze_link_if
    import maze_link_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BEATS  = DEF_BEATS,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [DATA_W-1:0]       link_data;
    logic                    link_strobe;
    logic [ADDR_W-1:0]       link_addr;

    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W*BEATS-1:0] wr_data;
    logic                    done;
    logic                    in_word;
    logic [7:0]              err_count;
    logic [ADDR_W:0]         cell_count;

    modport master (
        output link_data, link_strobe, link_addr,
        input  wr_en, wr_addr, wr_data, done, in_word, err_count, cell_count
    );

    modport slave (
        input  link_data, link_strobe, link_addr,
        output wr_en, wr_addr, wr_data, done, in_word, err_count, cell_count
    );
endinterface

// File: rtl/maze_link_rx_link_sync.sv
// ---------------------------------------------------------------------------
// link_sync
// Two-flop synchroniser for a W-bit asynchronous bus plus its strobe, with a
// rising-edge detector on the strobe.
//   clk         : sampling clock
//   srst        : synchronous active-high reset, clears every stage
//   bus_in      : asynchronous payload/address bits
//   strobe_in   : asynchronous beat strobe
//   bus_s2      : second-stage copy of bus_in
//   strobe_rise : high for one cycle when the second strobe stage is high
//                 and the third is still low
// ---------------------------------------------------------------------------
module link_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W-1:0] bus_in,
    input  logic         strobe_in,
    output logic [W-1:0] bus_s2,
    output logic         strobe_rise
);
    logic [W-1:0] bus_s1_q, bus_s1_d;
    logic [W-1:0] bus_s2_q, bus_s2_d;
    logic         stb_s1_q, stb_s1_d;
    logic         stb_s2_q, stb_s2_d;
    logic         stb_s3_q, stb_s3_d;

    always_comb begin
        bus_s1_d = bus_in;
        bus_s2_d = bus_s1_q;
        stb_s1_d = strobe_in;
        stb_s2_d = stb_s1_q;
        stb_s3_d = stb_s2_q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            bus_s1_q <= '0;
            bus_s2_q <= '0;
            stb_s1_q <= 1'b0;
            stb_s2_q <= 1'b0;
            stb_s3_q <= 1'b0;
        end else begin
            bus_s1_q <= bus_s1_d;
            bus_s2_q <= bus_s2_d;
            stb_s1_q <= stb_s1_d;
            stb_s2_q <= stb_s2_d;
            stb_s3_q <= stb_s3_d;
        end
    end

    assign bus_s2      = bus_s2_q;
    assign strobe_rise = stb_s2_q & ~stb_s3_q;
endmodule

// File: rtl/maze_link_rx.sv
// ---------------------------------------------------------------------------
// maze_link_rx
// Synchronous receiver for the Arduino maze link. Resynchronises the beat
// bus into CLOCK_25, reassembles BEATS-beat cell words LSB-first and emits a
// one-cycle write into the VGA cell RAM for every completed word.
//   CLOCK_25 : system clock
//   reset    : synchronous active-high reset
//   bus      : link pins in, RAM write port + done/in_word/err_count/
//              cell_count out (maze_link_if.slave)
// Control beats: SYNC_ADDR drops any partial word and clears cell_count;
// DONE_ADDR raises done. A partial word is aborted (and counted in
// err_count) by a beat to a different address, a DONE beat, or TIMEOUT idle
// cycles mid-word.
// ---------------------------------------------------------------------------
module maze_link_rx
    import maze_link_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BEATS     = DEF_BEATS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int SYNC_ADDR = sync_addr_of(ADDR_W),
    parameter int DONE_ADDR = done_addr_of(ADDR_W),
    parameter int TIMEOUT   = 4096
) (
    input  logic        CLOCK_25,
    input  logic        reset,
    maze_link_if.slave  bus
);
    localparam int WORD_W = DATA_W * BEATS;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0] SYNC_A   = ADDR_W'(SYNC_ADDR);
    localparam logic [ADDR_W-1:0] DONE_A   = ADDR_W'(DONE_ADDR);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Synchroniser: data and address share one bus through link_sync.
    // ------------------------------------------------------------------
    logic [DATA_W+ADDR_W-1:0] sync_bus;
    logic                     beat;
    logic [DATA_W-1:0]        beat_data;
    logic [ADDR_W-1:0]        beat_addr;

    link_sync #(.W(DATA_W + ADDR_W)) u_link_sync (
        .clk         (CLOCK_25),
        .srst        (reset),
        .bus_in      ({bus.link_addr, bus.link_data}),
        .strobe_in   (bus.link_strobe),
        .bus_s2      (sync_bus),
        .strobe_rise (beat)
    );

    assign beat_data = sync_bus[DATA_W-1:0];
    assign beat_addr = sync_bus[DATA_W +: ADDR_W];

    // ------------------------------------------------------------------
    // Assembly state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  beat_cnt_q,  beat_cnt_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic [WORD_W-1:0] word_q,      word_d;
    logic [IDLE_W-1:0] idle_q,      idle_d;
    logic              wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [WORD_W-1:0] wr_data_q,   wr_data_d;
    logic              done_q,      done_d;
    logic [7:0]        err_cnt_q,   err_cnt_d;
    logic [ADDR_W:0]   cell_cnt_q,  cell_cnt_d;

    logic              in_word;
    logic              timeout;
    logic              err_inc;
    logic              cell_inc;
    logic [CNT_W-1:0]  slot;

    assign in_word = (beat_cnt_q != '0);
    assign timeout = in_word && (idle_q == IDLE_MAX);

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        word_addr_d = word_addr_q;
        word_d      = word_q;
        idle_d      = '0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = done_q;
        err_inc     = 1'b0;
        cell_inc    = 1'b0;
        slot        = '0;

        // Idle timer only runs while a partial word is held; a beat in the
        // timeout cycle takes priority below, so no error is counted then.
        if (!beat && in_word && !timeout) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        if (beat) begin
            if (beat_addr == SYNC_A) begin
                beat_cnt_d = '0;
            end else if (beat_addr == DONE_A) begin
                done_d     = 1'b1;
                beat_cnt_d = '0;
                err_inc    = in_word;
            end else begin
                // Slot 0 for a fresh word, or a restart when the address
                // changed mid-word (the old partial word is an error).
                if (in_word && (beat_addr == word_addr_q)) begin
                    slot = beat_cnt_q;
                end else begin
                    slot    = '0;
                    err_inc = in_word;
                end

                if (slot == '0) begin
                    word_addr_d = beat_addr;
                    word_d      = '0;
                    done_d      = 1'b0;
                end
                word_d[int'(slot)*DATA_W +: DATA_W] = beat_data;

                if (slot == LAST_CNT) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = beat_addr;
                    wr_data_d  = word_d;
                    beat_cnt_d = '0;
                    cell_inc   = 1'b1;
                end else begin
                    beat_cnt_d = slot + CNT_W'(1);
                end
            end
        end else if (timeout) begin
            beat_cnt_d = '0;
            err_inc    = 1'b1;
        end

        err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

        if (beat && (beat_addr == SYNC_A)) begin
            cell_cnt_d = '0;
        end else if (cell_inc && (cell_cnt_q != '1)) begin
            cell_cnt_d = cell_cnt_q + (ADDR_W+1)'(1);
        end else begin
            cell_cnt_d = cell_cnt_q;
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            beat_cnt_q  <= '0;
            word_addr_q <= '0;
            word_q      <= '0;
            idle_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            err_cnt_q   <= '0;
            cell_cnt_q  <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            word_addr_q <= word_addr_d;
            word_q      <= word_d;
            idle_q      <= idle_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            err_cnt_q   <= err_cnt_d;
            cell_cnt_q  <= cell_cnt_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.done       = done_q;
    assign bus.in_word    = in_word;
    assign bus.err_count  = err_cnt_q;
    assign bus.cell_count = cell_cnt_q;
endmodule

// File: tb/tb_maze_link_rx.sv
// ---------------------------------------------------------------------------
// tb_maze_link_rx
// Directed bench for maze_link_rx with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_maze_link_rx;
    logic CLOCK_25 = 1'b0;
    logic reset    = 1'b1;

    maze_link_if #(.DATA_W(3), .BEATS(3), .ADDR_W(5)) bus ();

    maze_link_rx #(
        .DATA_W (3),
        .BEATS  (3),
        .ADDR_W (5),
        .TIMEOUT(4096)
    ) dut (
        .CLOCK_25 (CLOCK_25),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 CLOCK_25 = ~CLOCK_25;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Bench-side observers of the write port and in_word.
    int        wr_seen     = 0;
    logic [4:0] last_addr  = '0;
    logic [8:0] last_data  = '0;
    int        inword_cyc  = 0;

    always @(negedge CLOCK_25) begin
        if (bus.wr_en) begin
            wr_seen   = wr_seen + 1;
            last_addr = bus.wr_addr;
            last_data = bus.wr_data;
            $display("write: addr=%0d data=0x%03h", bus.wr_addr, bus.wr_data);
        end
        if (bus.in_word) inword_cyc = inword_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (got !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge CLOCK_25);
    endtask

    // One beat: payload/address set up 2 cycles early, strobe high for
    // hi cycles then low for lo cycles, payload held throughout.
    task automatic send_beat(input logic [4:0] a, input logic [2:0] d,
                             input int hi = 4, input int lo = 4);
        @(negedge CLOCK_25);
        bus.link_addr = a;
        bus.link_data = d;
        cycles(2);
        bus.link_strobe = 1'b1;
        cycles(hi);
        bus.link_strobe = 1'b0;
        cycles(lo);
    endtask

    task automatic send_word(input logic [4:0] a, input logic [2:0] d0,
                             input logic [2:0] d1, input logic [2:0] d2,
                             input int hi = 4, input int lo = 4);
        send_beat(a, d0, hi, lo);
        send_beat(a, d1, hi, lo);
        send_beat(a, d2, hi, lo);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int w0;

    initial begin
        bus.link_data   = '0;
        bus.link_addr   = '0;
        bus.link_strobe = 1'b0;
        cycles(3);
        chk("rst_wr_en",   32'(bus.wr_en),      32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr),    32'd0);
        chk("rst_wr_data", 32'(bus.wr_data),    32'd0);
        chk("rst_done",    32'(bus.done),       32'd0);
        chk("rst_in_word", 32'(bus.in_word),    32'd0);
        chk("rst_err",     32'(bus.err_count),  32'd0);
        chk("rst_cells",   32'(bus.cell_count), 32'd0);
        reset = 1'b0;
        cycles(2);

        // Basic word: addr 7, beats 5,2,6 -> 110_010_101
        send_beat(5'd7, 3'd5);
        chk("w1_in_word", 32'(bus.in_word), 32'd1);
        send_beat(5'd7, 3'd2);
        send_beat(5'd7, 3'd6);
        chk("w1_writes",  32'(wr_seen),        32'd1);
        chk("w1_addr",    32'(last_addr),      32'd7);
        chk("w1_data",    32'(last_data),      32'h195);
        chk("w1_cells",   32'(bus.cell_count), 32'd1);
        chk("w1_err",     32'(bus.err_count),  32'd0);
        chk("w1_idle",    32'(bus.in_word),    32'd0);
        chk("w1_hold",    32'(bus.wr_data),    32'h195);

        // Address change mid-word: abort + restart at addr 9 -> 010_000_011
        send_beat(5'd4, 3'd1);
        send_beat(5'd9, 3'd3);
        chk("w2_err",    32'(bus.err_count), 32'd1);
        send_beat(5'd9, 3'd0);
        send_beat(5'd9, 3'd2);
        chk("w2_writes", 32'(wr_seen),        32'd2);
        chk("w2_addr",   32'(last_addr),      32'd9);
        chk("w2_data",   32'(last_data),      32'h083);
        chk("w2_cells",  32'(bus.cell_count), 32'd2);

        // Timeout: in_word stays high for exactly TIMEOUT cycles.
        inword_cyc = 0;
        send_beat(5'd3, 3'd4);
        for (int i = 0; i < 4200 && bus.in_word; i++) @(negedge CLOCK_25);
        chk("to_in_word", 32'(bus.in_word),   32'd0);
        chk("to_cycles",  32'(inword_cyc),    32'd4096);
        chk("to_err",     32'(bus.err_count), 32'd2);
        chk("to_writes",  32'(wr_seen),       32'd2);
        send_word(5'd5, 3'd1, 3'd1, 3'd1);
        chk("w3_writes", 32'(wr_seen),        32'd3);
        chk("w3_addr",   32'(last_addr),      32'd5);
        chk("w3_data",   32'(last_data),      32'h049);
        chk("w3_cells",  32'(bus.cell_count), 32'd3);

        // DONE / SYNC handling
        send_beat(5'd30, 3'd0);
        chk("done_set",   32'(bus.done),       32'd1);
        chk("done_err",   32'(bus.err_count),  32'd2);
        send_beat(5'd31, 3'd0);
        chk("sync_done",  32'(bus.done),       32'd1);
        chk("sync_cells", 32'(bus.cell_count), 32'd0);
        send_beat(5'd6, 3'd7);
        chk("data_done",  32'(bus.done),       32'd0);
        chk("data_inw",   32'(bus.in_word),    32'd1);
        send_beat(5'd31, 3'd0);
        chk("sync_drop",  32'(bus.in_word),    32'd0);
        chk("sync_err",   32'(bus.err_count),  32'd2);
        send_beat(5'd8, 3'd2);
        send_beat(5'd30, 3'd0);
        chk("done_abort", 32'(bus.err_count),  32'd3);
        chk("done_inw",   32'(bus.in_word),    32'd0);

        // Reset mid-word
        send_beat(5'd2, 3'd1);
        send_beat(5'd2, 3'd2);
        @(negedge CLOCK_25);
        reset = 1'b1;
        @(negedge CLOCK_25);
        reset = 1'b0;
        chk("rst_mid_inw", 32'(bus.in_word), 32'd0);
        w0 = wr_seen;
        send_word(5'd2, 3'd3, 3'd4, 3'd5);
        chk("w4_writes", 32'(wr_seen - w0),   32'd1);
        chk("w4_addr",   32'(last_addr),      32'd2);
        chk("w4_data",   32'(last_data),      32'h163);
        chk("w4_err",    32'(bus.err_count),  32'd0);
        chk("w4_cells",  32'(bus.cell_count), 32'd1);

        // Narrow 2-cycle pulses: no requirement, then resync.
        send_word(5'd10, 3'd1, 3'd2, 3'd3, 2, 2);
        send_beat(5'd31, 3'd0);
        // 3-cycle pulses must not lose beats.
        w0 = wr_seen;
        send_word(5'd11, 3'd7, 3'd0, 3'd7, 3, 3);
        chk("w5_writes", 32'(wr_seen - w0),   32'd1);
        chk("w5_addr",   32'(last_addr),      32'd11);
        chk("w5_data",   32'(last_data),      32'h1C7);
        chk("w5_cells",  32'(bus.cell_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
